// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard unit: opcode encodings,
// the in-flight slot record and the hazard FSM states.
package pipeline_pkg;

    localparam int MAX_RW = 8;

    localparam logic [4:0] OP_MOV  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_CMP  = 5'b00011;
    localparam logic [4:0] OP_LD   = 5'b00100;
    localparam logic [4:0] OP_ST   = 5'b00101;
    localparam logic [4:0] OP_BRZ  = 5'b01001;
    localparam logic [4:0] OP_BRN  = 5'b01010;
    localparam logic [4:0] OP_CALL = 5'b01100;
    localparam logic [4:0] OP_LDI  = 5'b10000;
    localparam logic [4:0] OP_ADDI = 5'b10001;
    localparam logic [4:0] OP_SUBI = 5'b10010;
    localparam logic [4:0] OP_CMPI = 5'b10011;
    localparam logic [4:0] OP_SHL  = 5'b10110;

    // A call always links into R7.
    localparam logic [MAX_RW-1:0] CALL_DST = 8'd7;

    typedef struct packed {
        logic              valid;
        logic              wr_rf;
        logic              wr_nz;
        logic              is_load;
        logic [MAX_RW-1:0] dst;
    } slot_rec_t;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } haz_state_e;

endpackage

// File: rtl/hazard_opcode_class.sv
// Combinational opcode classifier: which operands an opcode reads and
// which architectural state (register file, NZ flags) it writes.
module hazard_opcode_class
    import pipeline_pkg::*;
(
    input  logic [4:0] opcode,
    output logic       wr_rf,
    output logic       wr_nz,
    output logic       is_load,
    output logic       is_call,
    output logic       rd_rx,
    output logic       rd_ry,
    output logic       rd_nz
);

    always_comb begin
        wr_rf   = 1'b0;
        wr_nz   = 1'b0;
        is_load = 1'b0;
        is_call = 1'b0;
        rd_rx   = 1'b0;
        rd_ry   = 1'b0;
        rd_nz   = 1'b0;
        case (opcode)
            OP_MOV:           begin wr_rf = 1'b1; rd_ry = 1'b1; end
            OP_ADD, OP_SUB:   begin wr_rf = 1'b1; wr_nz = 1'b1; rd_rx = 1'b1; rd_ry = 1'b1; end
            OP_CMP:           begin wr_nz = 1'b1; rd_rx = 1'b1; rd_ry = 1'b1; end
            OP_LD:            begin wr_rf = 1'b1; is_load = 1'b1; rd_ry = 1'b1; end
            OP_ST:            begin rd_rx = 1'b1; rd_ry = 1'b1; end
            OP_BRZ, OP_BRN:   rd_nz = 1'b1;
            OP_CALL:          begin wr_rf = 1'b1; is_call = 1'b1; end
            OP_LDI:           wr_rf = 1'b1;
            OP_ADDI, OP_SUBI: begin wr_rf = 1'b1; wr_nz = 1'b1; rd_rx = 1'b1; end
            OP_CMPI:          begin wr_nz = 1'b1; rd_rx = 1'b1; end
            OP_SHL:           begin wr_rf = 1'b1; rd_rx = 1'b1; end
            default:          ;
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Execute-to-writeback scoreboard: RAW stall, forwarding selects and branch flush.
// Define HAZ_FWD_EN to enable forwarding; otherwise consumers wait for writeback.
module pipeline_hazard_unit
    import pipeline_pkg::*;
#(
    parameter  int DEPTH    = 3,
    parameter  int NUM_REGS = 8,
    parameter  int CNT_W    = 16,
    localparam int RW       = $clog2(NUM_REGS),
    localparam int SW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [4:0]       dec_opcode,
    input  logic [RW-1:0]    dec_rx,
    input  logic [RW-1:0]    dec_ry,
    input  logic             br_taken,
    output logic             dec_stall,
    output logic             flush_fd,
    output logic             fwd_x_hit,
    output logic             fwd_y_hit,
    output logic             fwd_nz_hit,
    output logic [SW-1:0]    fwd_x_slot,
    output logic [SW-1:0]    fwd_y_slot,
    output logic [SW-1:0]    fwd_nz_slot,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_rec_t  slots [DEPTH];
    slot_rec_t  dec_rec;
    haz_state_e state, state_next;

    logic c_wr_rf, c_wr_nz, c_is_load, c_is_call, c_rd_rx, c_rd_ry, c_rd_nz;
    logic hazard;
    logic [MAX_RW-1:0] rx_ext, ry_ext;
    logic [DEPTH-2:0]  match_x, match_y, match_nz;

    hazard_opcode_class u_class (
        .opcode  (dec_opcode),
        .wr_rf   (c_wr_rf),
        .wr_nz   (c_wr_nz),
        .is_load (c_is_load),
        .is_call (c_is_call),
        .rd_rx   (c_rd_rx),
        .rd_ry   (c_rd_ry),
        .rd_nz   (c_rd_nz)
    );

    assign rx_ext = MAX_RW'(dec_rx);
    assign ry_ext = MAX_RW'(dec_ry);

    always_comb begin
        dec_rec         = '0;
        dec_rec.valid   = 1'b1;
        dec_rec.wr_rf   = c_wr_rf;
        dec_rec.wr_nz   = c_wr_nz;
        dec_rec.is_load = c_is_load;
        dec_rec.dst     = c_is_call ? MAX_RW'(CALL_DST[RW-1:0]) : rx_ext;
    end

    // The writeback slot is excluded: the register file writes through.
    always_comb begin
        match_x  = '0;
        match_y  = '0;
        match_nz = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            match_x[i]  = dec_valid & c_rd_rx & slots[i].valid & slots[i].wr_rf & (slots[i].dst == rx_ext);
            match_y[i]  = dec_valid & c_rd_ry & slots[i].valid & slots[i].wr_rf & (slots[i].dst == ry_ext);
            match_nz[i] = dec_valid & c_rd_nz & slots[i].valid & slots[i].wr_nz;
        end
    end

`ifdef HAZ_FWD_EN
    function automatic logic [SW:0] youngest(input logic [DEPTH-2:0] m);
        youngest = '0;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            if (m[i]) youngest = {1'b1, SW'(i)};
        end
    endfunction

    logic [SW:0] sel_x, sel_y, sel_nz;
    logic        load_x, load_y;

    assign sel_x  = youngest(match_x);
    assign sel_y  = youngest(match_y);
    assign sel_nz = youngest(match_nz);

    // A load still in execute has no data yet; it becomes forwardable from slot 1.
    assign load_x = sel_x[SW] && (sel_x[SW-1:0] == '0) && slots[0].is_load;
    assign load_y = sel_y[SW] && (sel_y[SW-1:0] == '0) && slots[0].is_load;
    assign hazard = load_x | load_y;

    assign fwd_x_hit   = sel_x[SW] & ~load_x;
    assign fwd_y_hit   = sel_y[SW] & ~load_y;
    assign fwd_nz_hit  = sel_nz[SW];
    assign fwd_x_slot  = fwd_x_hit ? sel_x[SW-1:0] : '0;
    assign fwd_y_slot  = fwd_y_hit ? sel_y[SW-1:0] : '0;
    assign fwd_nz_slot = sel_nz[SW-1:0];
`else
    assign hazard      = (|match_x) | (|match_y) | (|match_nz);
    assign fwd_x_hit   = 1'b0;
    assign fwd_y_hit   = 1'b0;
    assign fwd_nz_hit  = 1'b0;
    assign fwd_x_slot  = '0;
    assign fwd_y_slot  = '0;
    assign fwd_nz_slot = '0;
`endif

    assign dec_stall = hazard & ~br_taken;
    assign flush_fd  = br_taken & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else begin
            slots[0] <= (dec_valid && !dec_stall && !br_taken) ? dec_rec : '0;
            for (int i = 1; i < DEPTH; i++) slots[i] <= slots[i-1];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (br_taken) state_next = FLUSH; else if (hazard) state_next = STALL;
            STALL:   if (br_taken) state_next = FLUSH; else if (!hazard) state_next = RUN;
            FLUSH:   if (!br_taken) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            if (dec_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit; expected tables follow HAZ_FWD_EN.
// A second instance with an 8-bit counter exercises counter saturation quickly.
module tb_pipeline_hazard_unit;
    import pipeline_pkg::*;

    localparam int SW = 2;
    localparam int OW = 5 + 3 * SW;

    typedef struct packed {
        logic          valid;
        logic [4:0]    op;
        logic [2:0]    rx;
        logic [2:0]    ry;
        logic          br;
        logic [OW-1:0] exp;
    } step_t;

    logic clk = 1'b0;
    logic reset;
    logic dec_valid, br_taken;
    logic [4:0] dec_opcode;
    logic [2:0] dec_rx, dec_ry;

    logic dec_stall, flush_fd, fwd_x_hit, fwd_y_hit, fwd_nz_hit;
    logic [SW-1:0] fwd_x_slot, fwd_y_slot, fwd_nz_slot;
    logic [15:0] stall_cnt;

    logic s_dec_stall, s_flush_fd, s_fwd_x_hit, s_fwd_y_hit, s_fwd_nz_hit;
    logic [SW-1:0] s_fwd_x_slot, s_fwd_y_slot, s_fwd_nz_slot;
    logic [7:0] s_stall_cnt;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    logic [OW-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_unit #(.DEPTH(3), .NUM_REGS(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_opcode(dec_opcode),
        .dec_rx(dec_rx), .dec_ry(dec_ry), .br_taken(br_taken),
        .dec_stall(dec_stall), .flush_fd(flush_fd),
        .fwd_x_hit(fwd_x_hit), .fwd_y_hit(fwd_y_hit), .fwd_nz_hit(fwd_nz_hit),
        .fwd_x_slot(fwd_x_slot), .fwd_y_slot(fwd_y_slot), .fwd_nz_slot(fwd_nz_slot),
        .stall_cnt(stall_cnt)
    );

    pipeline_hazard_unit #(.DEPTH(3), .NUM_REGS(8), .CNT_W(8)) dut_small (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_opcode(dec_opcode),
        .dec_rx(dec_rx), .dec_ry(dec_ry), .br_taken(br_taken),
        .dec_stall(s_dec_stall), .flush_fd(s_flush_fd),
        .fwd_x_hit(s_fwd_x_hit), .fwd_y_hit(s_fwd_y_hit), .fwd_nz_hit(s_fwd_nz_hit),
        .fwd_x_slot(s_fwd_x_slot), .fwd_y_slot(s_fwd_y_slot), .fwd_nz_slot(s_fwd_nz_slot),
        .stall_cnt(s_stall_cnt)
    );

    wire [OW-1:0] obs   = {dec_stall, flush_fd, fwd_x_hit, fwd_y_hit, fwd_nz_hit,
                           fwd_x_slot, fwd_y_slot, fwd_nz_slot};
    wire [OW-1:0] s_obs = {s_dec_stall, s_flush_fd, s_fwd_x_hit, s_fwd_y_hit, s_fwd_nz_hit,
                           s_fwd_x_slot, s_fwd_y_slot, s_fwd_nz_slot};

    function automatic logic [OW-1:0] e(input logic st, fl, xh, yh, nh, input int xs, ys, ns);
        return {st, fl, xh, yh, nh, SW'(xs), SW'(ys), SW'(ns)};
    endfunction

    function automatic step_t mk_step(input logic v, input logic [4:0] op, input int rx, ry,
                                      input logic br, input logic [OW-1:0] ex);
        step_t t;
        t.valid = v;
        t.op    = op;
        t.rx    = 3'(rx);
        t.ry    = 3'(ry);
        t.br    = br;
        t.exp   = ex;
        return t;
    endfunction

    task automatic drive(input step_t t);
        dec_valid  = t.valid;
        dec_opcode = t.op;
        dec_rx     = t.rx;
        dec_ry     = t.ry;
        br_taken   = t.br;
    endtask

    task automatic drain();
        repeat (3) begin
            @(posedge clk); #1;
            dec_valid = 1'b0;
            br_taken  = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [OW-1:0] want;
        reset = 1'b0; dec_valid = 1'b0; br_taken = 1'b0;
        dec_opcode = '0; dec_rx = '0; dec_ry = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        want = '0;
        checks++;
        if (obs !== want) begin failures++; $display("[TB] FAIL reset_outputs: got %b expected %b", obs, want); end
        checks++;
        if (stall_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_cnt: got %0d expected 0", stall_cnt); end
        checks++;
        if (s_stall_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_small_cnt: got %0d expected 0", s_stall_cnt); end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_raw();
        step_t seq[$];
        logic [OW-1:0] want;
        seq.push_back(mk_step(1, OP_ADD, 1, 0, 0, e(0,0,0,0,0,0,0,0)));
`ifdef HAZ_FWD_EN
        seq.push_back(mk_step(1, OP_ADD, 1, 3, 0, e(0,0,1,0,0,0,0,0)));
        seq.push_back(mk_step(0, OP_MOV, 0, 0, 0, e(0,0,0,0,0,0,0,0)));
        seq.push_back(mk_step(1, OP_ADD, 1, 1, 0, e(0,0,1,1,0,1,1,0)));
`else
        seq.push_back(mk_step(1, OP_ADD, 1, 3, 0, e(1,0,0,0,0,0,0,0)));
        seq.push_back(mk_step(1, OP_ADD, 1, 3, 0, e(1,0,0,0,0,0,0,0)));
        seq.push_back(mk_step(1, OP_ADD, 1, 3, 0, e(0,0,0,0,0,0,0,0)));
`endif
        foreach (seq[i]) begin
            @(posedge clk); #1;
            drive(seq[i]);
            exp_q.push_back(seq[i].exp);
            if (seq[i].exp[OW-1]) exp_cnt++;
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin failures++; $display("[TB] FAIL raw step %0d: got %b expected %b", i, obs, want); end
        end
        drain();
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin failures++; $display("[TB] FAIL raw_cnt: got %0d expected %0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_load_use();
        step_t seq[$];
        logic [OW-1:0] want;
        seq.push_back(mk_step(1, OP_LD, 2, 5, 0, e(0,0,0,0,0,0,0,0)));
        seq.push_back(mk_step(1, OP_ADD, 4, 2, 0, e(1,0,0,0,0,0,0,0)));
`ifdef HAZ_FWD_EN
        seq.push_back(mk_step(1, OP_ADD, 4, 2, 0, e(0,0,0,1,0,0,1,0)));
`else
        seq.push_back(mk_step(1, OP_ADD, 4, 2, 0, e(1,0,0,0,0,0,0,0)));
        seq.push_back(mk_step(1, OP_ADD, 4, 2, 0, e(0,0,0,0,0,0,0,0)));
`endif
        foreach (seq[i]) begin
            @(posedge clk); #1;
            drive(seq[i]);
            exp_q.push_back(seq[i].exp);
            if (seq[i].exp[OW-1]) exp_cnt++;
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin failures++; $display("[TB] FAIL load_use step %0d: got %b expected %b", i, obs, want); end
        end
        drain();
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin failures++; $display("[TB] FAIL load_use_cnt: got %0d expected %0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_flags();
        step_t seq[$];
        logic [OW-1:0] want;
        seq.push_back(mk_step(1, OP_CMP, 1, 2, 0, e(0,0,0,0,0,0,0,0)));
`ifdef HAZ_FWD_EN
        seq.push_back(mk_step(1, OP_BRZ, 0, 0, 0, e(0,0,0,0,1,0,0,0)));
        seq.push_back(mk_step(1, OP_BRZ, 0, 0, 0, e(0,0,0,0,1,0,0,1)));
        seq.push_back(mk_step(1, OP_BRZ, 0, 0, 0, e(0,0,0,0,0,0,0,0)));
`else
        seq.push_back(mk_step(1, OP_BRZ, 0, 0, 0, e(1,0,0,0,0,0,0,0)));
        seq.push_back(mk_step(1, OP_BRZ, 0, 0, 0, e(1,0,0,0,0,0,0,0)));
        seq.push_back(mk_step(1, OP_BRZ, 0, 0, 0, e(0,0,0,0,0,0,0,0)));
        seq.push_back(mk_step(1, OP_BRZ, 0, 0, 0, e(0,0,0,0,0,0,0,0)));
`endif
        foreach (seq[i]) begin
            @(posedge clk); #1;
            drive(seq[i]);
            exp_q.push_back(seq[i].exp);
            if (seq[i].exp[OW-1]) exp_cnt++;
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin failures++; $display("[TB] FAIL flags step %0d: got %b expected %b", i, obs, want); end
        end
        drain();
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin failures++; $display("[TB] FAIL flags_cnt: got %0d expected %0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_branch_flush();
        step_t seq[$];
        logic [OW-1:0] want;
        seq.push_back(mk_step(1, OP_ADD, 1, 0, 0, e(0,0,0,0,0,0,0,0)));
`ifdef HAZ_FWD_EN
        seq.push_back(mk_step(1, OP_ADD, 1, 0, 1, e(0,1,1,0,0,0,0,0)));
        seq.push_back(mk_step(1, OP_ADD, 1, 0, 0, e(0,0,1,0,0,1,0,0)));
        seq.push_back(mk_step(1, OP_ADD, 1, 0, 0, e(0,0,1,0,0,0,0,0)));
`else
        seq.push_back(mk_step(1, OP_ADD, 1, 0, 1, e(0,1,0,0,0,0,0,0)));
        seq.push_back(mk_step(1, OP_ADD, 1, 0, 0, e(1,0,0,0,0,0,0,0)));
        seq.push_back(mk_step(1, OP_ADD, 1, 0, 0, e(0,0,0,0,0,0,0,0)));
`endif
        foreach (seq[i]) begin
            @(posedge clk); #1;
            drive(seq[i]);
            exp_q.push_back(seq[i].exp);
            if (seq[i].exp[OW-1]) exp_cnt++;
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin failures++; $display("[TB] FAIL branch step %0d: got %b expected %b", i, obs, want); end
            if (i == 2) begin
                checks++;
                if (dut.state !== FLUSH) begin failures++; $display("[TB] FAIL branch_state_flush: got %0d expected %0d", dut.state, FLUSH); end
            end
            if (i == 3) begin
                checks++;
                if (dut.state !== RUN) begin failures++; $display("[TB] FAIL branch_state_run: got %0d expected %0d", dut.state, RUN); end
            end
        end
        drain();
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin failures++; $display("[TB] FAIL branch_cnt: got %0d expected %0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        logic [OW-1:0] want;
        @(posedge clk); #1;
        drive(mk_step(1, OP_LD, 2, 5, 0, '0));
        @(posedge clk); #1;
        drive(mk_step(1, OP_ADD, 4, 2, 0, '0));
        exp_q.push_back(e(1,0,0,0,0,0,0,0));
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin failures++; $display("[TB] FAIL midreset_stall: got %b expected %b", obs, want); end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin failures++; $display("[TB] FAIL midreset_outputs: got %b expected 0", obs); end
        checks++;
        if (stall_cnt !== 16'd0) begin failures++; $display("[TB] FAIL midreset_cnt: got %0d expected 0", stall_cnt); end
        exp_cnt = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.push_back(e(0,0,0,0,0,0,0,0));
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin failures++; $display("[TB] FAIL midreset_no_stale: got %b expected %b", obs, want); end
        drain();
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin failures++; $display("[TB] FAIL midreset_cnt_after: got %0d expected %0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_saturation();
        logic [OW-1:0] want;
        logic st;
        checks++;
        if (s_stall_cnt !== 8'(exp_cnt)) begin failures++; $display("[TB] FAIL sat_start: got %0d expected %0d", s_stall_cnt, exp_cnt); end
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            drive(mk_step(1, OP_LD, 1, 1, 0, '0));
`ifdef HAZ_FWD_EN
            st = (i % 2) == 1;
            want = st ? e(1,0,0,0,0,0,0,0) : ((i == 0) ? e(0,0,0,0,0,0,0,0) : e(0,0,0,1,0,0,1,0));
`else
            st = (i % 3) != 0;
            want = st ? e(1,0,0,0,0,0,0,0) : e(0,0,0,0,0,0,0,0);
`endif
            exp_q.push_back(want);
            if (st) exp_cnt++;
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want || s_obs !== want) begin
                failures++;
                $display("[TB] FAIL sat_step %0d: got %b / %b expected %b", i, obs, s_obs, want);
            end
        end
        drain();
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin failures++; $display("[TB] FAIL sat_wide_cnt: got %0d expected %0d", stall_cnt, exp_cnt); end
        checks++;
        if (s_stall_cnt !== 8'hFF) begin failures++; $display("[TB] FAIL sat_small_cnt: got %0d expected 255", s_stall_cnt); end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_raw();
        test_load_use();
        test_flags();
        test_branch_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised successor to the single-stage dependency check: a scoreboard that tracks every in-flight instruction from execute to writeback, stalls decode on unresolvable RAW hazards (register file and NZ flags), generates forwarding selects, and sequences the decode/fetch flush on a taken branch. It sits beside the pipeline decoder, reads the decode-stage instruction, and drives decode hold, forwarding muxes in execute, and fetch/decode flush.

## Interface
- `DEPTH`, 3: in-flight slots; slot 0 = execute, slot DEPTH-1 = writeback; legal 2..8
- `NUM_REGS`, 8: architectural registers; register index width `RW = $clog2(NUM_REGS)`
- `CNT_W`, 16: stall counter width
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-low reset
- `dec_valid` in 1: decode holds a valid instruction
- `dec_opcode` in 5: decode opcode
- `dec_rx` in RW: decode Rx field
- `dec_ry` in RW: decode Ry field
- `br_taken` in 1: branch in slot 0 resolved taken this cycle
- `dec_stall` out 1: hold fetch/decode, insert bubble into slot 0
- `flush_fd` out 1: squash fetch and decode contents
- `fwd_x_hit`, `fwd_y_hit`, `fwd_nz_hit` out 1 each: operand/flags taken from a forwarded slot
- `fwd_x_slot`, `fwd_y_slot`, `fwd_nz_slot` out `$clog2(DEPTH)`: source slot index
- `stall_cnt` out CNT_W: saturating count of stall cycles

## Operation
- Opcode classes: writes RF = 00000, 00001, 00010, 00100, 10000, 10001, 10010, 10110, 01100 (call, dst R7). Load = 00100. Writes NZ = 00001, 00010, 00011, 10001, 10010, 10011. Reads Rx = 00001, 00010, 00011, 00101, 10001, 10010, 10011, 10110. Reads Ry = 00000, 00001, 00010, 00011, 00100, 00101. Reads NZ = 01001, 01010. All other opcodes read and write nothing.
- Each slot holds a record: valid, wr_rf, wr_nz, is_load, dst. Slots shift toward writeback every cycle. Slot 0 is loaded from decode when `dec_valid & !dec_stall & !br_taken`; otherwise slot 0 takes a bubble (valid=0).
- Hazard match: a valid slot with `wr_rf` and `dst` equal to a read source, or with `wr_nz` when the instruction reads NZ. Slot DEPTH-1 never matches because the register file is write-through.
- `br_taken`: `flush_fd`=1 for exactly that cycle, `dec_stall` forced 0, and the wrong-path decode instruction is dropped. Older slots are untouched.
- FSM states: RUN, STALL, FLUSH. RUN→STALL on hazard; STALL→RUN when the hazard clears; any state→FLUSH on `br_taken`; FLUSH→RUN next cycle unless `br_taken` is asserted again. If `br_taken` and a hazard occur together, the flush wins.
- `stall_cnt` increments on every cycle with `dec_stall`=1 and saturates at all-ones.

## Timing
- `dec_stall`, `flush_fd`, and the `fwd_*` outputs are combinational in the same cycle from slot registers plus decode and `br_taken` inputs. Records, FSM, and counter update on the rising edge of `clk`.
- Reset (asserted low, asynchronous): all slots invalid, FSM=RUN, `stall_cnt`=0. Consequently `dec_stall`=0, `flush_fd`=0, all `fwd_*`=0.
- Reset during a stall or flush aborts it immediately. There is no pending state after release.

## Configuration
- `HAZ_FWD_EN` defined: a match is forwarded from the youngest matching slot (lowest index) with `fwd_*_hit`=1. A load matching in slot 0 stalls exactly 1 cycle, then forwards from slot 1.
- `HAZ_FWD_EN` undefined: all `fwd_*` outputs are tied 0. Any match in slots 0..DEPTH-2 stalls until the producer reaches slot DEPTH-1.

## Structure
- `pipeline_pkg`: opcode localparams, `slot_rec_t` struct, `haz_state_e` enum.
- Sub-module `hazard_opcode_class`: combinational opcode→class decode, instantiated once for decode.

## Test plan
- add R1 (01 00001, dst=1) then add reading Rx=1, DEPTH=3, FWD on → `dec_stall`=0, `fwd_x_hit`=1, `fwd_x_slot`=0. FWD off → 2 stall cycles, `stall_cnt`=2.
- ld R2 then add reading Ry=2, FWD on → 1 stall cycle, then `fwd_y_hit`=1, `fwd_y_slot`=1.
- cmp then brz (01001) → FWD on: `fwd_nz_hit`=1, `fwd_nz_slot`=0. FWD off: stall until cmp is in slot 2.
- `br_taken`=1 while decode has a hazard → `flush_fd`=1, `dec_stall`=0, slot 0 receives a bubble next cycle, FSM=FLUSH then RUN.
- Force 70000 stall cycles with CNT_W=16 → `stall_cnt` holds 16'hFFFF.
- `reset` pulled low mid-stall → all outputs 0 asynchronously. After release, no hazard is flagged against the pre-reset producer.
